// File: rtl/aes_pkg.sv
// Shared types for the AES request driver.
// Holds the datapath width and the driver FSM state encoding.
package aes_pkg;
  localparam int AES_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RESP
  } state_e;
endpackage

// File: rtl/aes_req_driver_if.sv
// Request, response and core-side signals of the AES request driver.
// master: the driver. slave: whoever sits around it (requester, consumer, core).
interface aes_req_driver_if;
  import aes_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [AES_W-1:0] req_key;
  logic [AES_W-1:0] req_text;
  logic             req_mode;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [AES_W-1:0] rsp_text;
  logic             rsp_err;

  logic             aes_ld;
  logic [AES_W-1:0] aes_key;
  logic [AES_W-1:0] aes_text_in;
  logic             aes_mode;
  logic             aes_done;
  logic [AES_W-1:0] aes_text_out;

  modport master (
    input  req_valid, req_key, req_text, req_mode,
    input  rsp_ready,
    input  aes_done, aes_text_out,
    output req_ready,
    output rsp_valid, rsp_text, rsp_err,
    output aes_ld, aes_key, aes_text_in, aes_mode
  );

  modport slave (
    output req_valid, req_key, req_text, req_mode,
    output rsp_ready,
    output aes_done, aes_text_out,
    input  req_ready,
    input  rsp_valid, rsp_text, rsp_err,
    input  aes_ld, aes_key, aes_text_in, aes_mode
  );
endinterface

// File: rtl/aes_req_driver.sv
// Drives one AES operation at a time: latch request, pulse aes_ld, wait for
// aes_done with timeout, hold response until taken. Ports: clk, rst (async
// active-low), bus (master modport), ops_cnt (completed responses).
module aes_req_driver
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  aes_req_driver_if.master  bus,
  output logic [15:0]       ops_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Timer hits TIMEOUT_CYCLES-1 on the increment out of this value.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AES_W-1:0] key_q, key_d;
  logic [AES_W-1:0] txt_q, txt_d;
  logic             mode_q, mode_d;
  logic [AES_W-1:0] rsp_q, rsp_d;
  logic             err_q, err_d;
  logic [15:0]      ops_cnt_q, ops_cnt_d;
  logic             expire;

  assign expire = (timer_q == T_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: if (bus.aes_done || expire) state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == ST_IDLE);
    bus.aes_ld    = (state_q == ST_LOAD);
    bus.rsp_valid = (state_q == ST_RESP);
  end

  always_comb begin
    key_d     = key_q;
    txt_d     = txt_q;
    mode_d    = mode_q;
    timer_d   = timer_q;
    rsp_d     = rsp_q;
    err_d     = err_q;
    ops_cnt_d = ops_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          key_d  = bus.req_key;
          txt_d  = bus.req_text;
          mode_d = bus.req_mode;
        end
      end
      ST_LOAD: timer_d = '0;
      ST_WAIT: begin
        // done wins over a timeout in the same cycle
        if (bus.aes_done) begin
          rsp_d = bus.aes_text_out;
          err_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
          if (expire) begin
            rsp_d = '0;
            err_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) ops_cnt_d = ops_cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= '0;
      key_q     <= '0;
      txt_q     <= '0;
      mode_q    <= 1'b0;
      rsp_q     <= '0;
      err_q     <= 1'b0;
      ops_cnt_q <= '0;
    end else begin
      timer_q   <= timer_d;
      key_q     <= key_d;
      txt_q     <= txt_d;
      mode_q    <= mode_d;
      rsp_q     <= rsp_d;
      err_q     <= err_d;
      ops_cnt_q <= ops_cnt_d;
    end
  end

  assign bus.aes_key     = key_q;
  assign bus.aes_text_in = txt_q;
  assign bus.aes_mode    = mode_q;
  assign bus.rsp_text    = rsp_q;
  assign bus.rsp_err     = err_q;
  assign ops_cnt         = ops_cnt_q;

endmodule

// File: tb/tb_aes_req_driver.sv
// Directed bench for aes_req_driver with a delay-programmable core model.
// Expected responses are queued at request time and popped at handshake.
module tb_aes_req_driver;
  import aes_pkg::*;

  typedef struct packed {
    logic [AES_W-1:0] text;
    logic             err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ops_cnt;

  aes_req_driver_if bus ();

  aes_req_driver #(.TIMEOUT_CYCLES(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ops_cnt (ops_cnt)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  int unsigned cyc    = 0;
  int unsigned ld_cyc = 0;
  exp_t        sb[$];
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done fires m_delay cycles after the LOAD cycle (0 = never).
  int               m_delay  = 0;
  int               m_cnt    = 0;
  int               ld_count = 0;
  logic [AES_W-1:0] m_out    = '0;

  always @(posedge clk) begin
    #1;
    bus.aes_text_out = m_out;
    if (bus.aes_ld === 1'b1) begin
      ld_count++;
      m_cnt        = m_delay;
      bus.aes_done = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      bus.aes_done = (m_cnt == 0);
    end else begin
      bus.aes_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_aes_ld"}, bus.aes_ld, 0);
    chk({tag, "_aes_key"}, bus.aes_key, 0);
    chk({tag, "_aes_text_in"}, bus.aes_text_in, 0);
    chk({tag, "_aes_mode"}, bus.aes_mode, 0);
    chk({tag, "_rsp_text"}, bus.rsp_text, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_ops_cnt"}, ops_cnt, 0);
  endtask

  // Timeout fires in the WAIT cycle LOAD+63; done at LOAD+d wins if d<=63.
  function automatic exp_t predict(input int d, input logic [127:0] o);
    exp_t e;
    if (d >= 1 && d <= 63) e = '{text: o, err: 1'b0};
    else e = '{text: '0, err: 1'b1};
    return e;
  endfunction

  task automatic do_req(input logic [127:0] k, input logic [127:0] t,
                        input logic m, input int d,
                        input logic [127:0] o, input bit push);
    m_delay = d;
    m_out   = o;
    for (int i = 0; i < 300 && bus.req_ready !== 1'b1; i++) tick();
    chk("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_key   = k;
    bus.req_text  = t;
    bus.req_mode  = m;
    tick();
    bus.req_valid = 1'b0;
    bus.req_key   = ~k;
    bus.req_text  = ~t;
    bus.req_mode  = ~m;
    ld_cyc = cyc;
    chk("aes_ld", bus.aes_ld, 1);
    chk("aes_key", bus.aes_key, k);
    chk("aes_text_in", bus.aes_text_in, t);
    chk("aes_mode", bus.aes_mode, m);
    chk("req_ready_busy", bus.req_ready, 0);
    if (push) sb.push_back(predict(d, o));
    tick();
    chk("aes_ld_pulse", bus.aes_ld, 0);
    chk("aes_key_hold", bus.aes_key, k);
  endtask

  task automatic wait_rsp(input int lat);
    for (int i = 0; i < 200 && bus.rsp_valid !== 1'b1; i++) tick();
    chk("rsp_valid", bus.rsp_valid, 1);
    if (lat >= 0) chk("latency", 128'(cyc - ld_cyc), 128'(lat));
  endtask

  task automatic take_rsp();
    exp_t e;
    chk("sb_nonempty", 128'(sb.size() > 0), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("rsp_text", bus.rsp_text, e.text);
    chk("rsp_err", bus.rsp_err, e.err);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("ops_cnt", ops_cnt, exp_cnt);
    chk("rsp_valid_drop", bus.rsp_valid, 0);
  endtask

  logic [127:0] k0 = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] t0 = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] c0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int           ldc;
    bit           stable;
    bit           rdy_seen;
    bit           rsp_seen;
    logic [127:0] snap_t;
    logic         snap_e;

    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_text  = '0;
    bus.req_mode  = 1'b0;
    bus.rsp_ready = 1'b0;
    tick(3);
    chk_reset_vals("rst");
    rst = 1'b1;
    tick();

    // Known-answer vector, done 11 cycles after LOAD.
    ldc = ld_count;
    do_req(k0, t0, 1'b1, 11, c0, 1'b1);
    wait_rsp(12);
    take_rsp();
    chk("kat_ld_pulses", 128'(ld_count - ldc), 1);
    chk("kat_ops_cnt", ops_cnt, 1);

    // Minimum latency: done in the first WAIT cycle.
    do_req(128'h1, 128'h2, 1'b0, 1, 128'hdead_beef, 1'b1);
    wait_rsp(2);
    take_rsp();

    // Core never answers.
    do_req(128'h3, 128'h4, 1'b1, 0, 128'hffff, 1'b1);
    wait_rsp(64);
    take_rsp();

    // done coincident with timeout expiry, then done one cycle too late.
    do_req(128'h5, 128'h6, 1'b0, 63, 128'hc0ffee, 1'b1);
    wait_rsp(64);
    take_rsp();
    do_req(128'h7, 128'h8, 1'b0, 64, 128'hbad, 1'b1);
    wait_rsp(64);
    take_rsp();

    // Backpressure with a second request waiting.
    do_req(128'h9, 128'ha, 1'b1, 4, 128'h1234, 1'b1);
    wait_rsp(5);
    snap_t = bus.rsp_text;
    snap_e = bus.rsp_err;
    bus.req_valid = 1'b1;
    bus.req_key   = 128'hb;
    bus.req_text  = 128'hc;
    bus.req_mode  = 1'b0;
    ldc      = ld_count;
    stable   = 1'b1;
    rdy_seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_text !== snap_t ||
          bus.rsp_err !== snap_e) stable = 1'b0;
      if (bus.req_ready !== 1'b0) rdy_seen = 1'b1;
    end
    chk("bp_stable", 128'(stable), 1);
    chk("bp_req_ready_low", 128'(rdy_seen), 0);
    chk("bp_no_ld", 128'(ld_count - ldc), 0);
    m_out = 128'h5678;
    take_rsp();
    chk("bp_req_ready_after", bus.req_ready, 1);
    chk("bp_ld_not_yet", bus.aes_ld, 0);
    tick();
    bus.req_valid = 1'b0;
    ld_cyc = cyc;
    chk("bp_second_ld", bus.aes_ld, 1);
    chk("bp_second_key", bus.aes_key, 128'hb);
    sb.push_back(predict(4, 128'h5678));
    wait_rsp(5);
    take_rsp();

    // Reset mid-WAIT, core answers after release.
    do_req(128'hd, 128'he, 1'b1, 10, 128'h9999, 1'b0);
    tick(2);
    rst = 1'b0;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b1;
    exp_cnt  = 16'd0;
    rsp_seen = 1'b0;
    repeat (15) begin
      tick();
      if (bus.rsp_valid !== 1'b0) rsp_seen = 1'b1;
    end
    chk("midrst_no_rsp", 128'(rsp_seen), 0);
    chk_reset_vals("midrst_after");

    // Counter wrap: preload near the top, then run three operations.
    force dut.ops_cnt_q = 16'hfffe;
    tick();
    release dut.ops_cnt_q;
    tick();
    exp_cnt = 16'hfffe;
    chk("wrap_preload", ops_cnt, exp_cnt);
    for (int i = 0; i < 3; i++) begin
      do_req(128'(i), 128'(i + 100), 1'b0, 1, 128'(i + 7), 1'b1);
      wait_rsp(2);
      take_rsp();
    end
    chk("wrap_final", ops_cnt, 16'h0001);
    chk("sb_drained", 128'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_req_driver.md
AES_REQ_DRIVER -- requirements
Module: aes_req_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles to wait for aes_done before error response; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: driver accepts request.
REQ-006 SHALL have port req_key, input, 128: cipher key.
REQ-007 SHALL have port req_text, input, 128: input block.
REQ-008 SHALL have port req_mode, input, 1: core mode bit, passed through unmodified.
REQ-009 SHALL have port rsp_valid, output, 1: response present.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts response.
REQ-011 SHALL have port rsp_text, output, 128: result block.
REQ-012 SHALL have port rsp_err, output, 1: 1 = timeout, rsp_text is zero.
REQ-013 SHALL have ports aes_ld (out, 1), aes_key (out, 128), aes_text_in (out, 128), aes_mode (out, 1): core load side.
REQ-014 SHALL have ports aes_done (in, 1) and aes_text_out (in, 128): core result side.
REQ-015 SHALL have port ops_cnt, output, 16: count of completed responses.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> WAIT -> RESP -> IDLE; one operation in flight.
REQ-017 SHALL drive req_ready = 1 only in IDLE.
REQ-018 SHALL, on req_valid & req_ready in cycle N, register req_key/req_text/req_mode onto aes_key/aes_text_in/aes_mode, visible in N+1, and enter LOAD.
REQ-019 SHALL assert aes_ld for exactly one cycle, in LOAD (cycle N+1), then enter WAIT with timer = 0.
REQ-020 SHALL hold aes_key/aes_text_in/aes_mode stable from LOAD until the next accepted request.
REQ-021 SHALL, in WAIT, increment timer each cycle aes_done = 0.
REQ-022 SHALL, on aes_done = 1 in WAIT, capture aes_text_out into rsp_text, clear rsp_err, enter RESP next cycle.
REQ-023 SHALL, if timer reaches TIMEOUT_CYCLES-1 with aes_done = 0, set rsp_text = 0, rsp_err = 1, enter RESP.
REQ-024 SHALL give aes_done priority when it coincides with timeout expiry (rsp_err = 0).
REQ-025 SHALL ignore aes_done in IDLE, LOAD and RESP.
REQ-026 SHALL assert rsp_valid only in RESP, holding rsp_text/rsp_err stable until rsp_valid & rsp_ready.
REQ-027 SHALL, on response handshake, return to IDLE and increment ops_cnt, wrapping 0xFFFF -> 0x0000; timeout responses are counted.
REQ-028 SHALL give minimum request-to-response latency of 3 cycles when aes_done arrives in the first WAIT cycle; next request is accepted no earlier than the cycle after the response handshake.
REQ-029 SHALL have no combinational path from req_valid or rsp_ready to any output.

Reset
REQ-030 SHALL, while rst = 0, force state IDLE, timer 0, aes_ld 0, aes_key/aes_text_in 0, aes_mode 0, rsp_valid 0, rsp_text 0, rsp_err 0, ops_cnt 0; req_ready reads 1.
REQ-031 SHALL abandon any in-flight operation on reset mid-operation with no response issued; a late aes_done after reset release is ignored per REQ-025.

Structure
REQ-032 SHALL place the state enum typedef and AES_W = 128 in shared package aes_pkg.
REQ-033 SHALL be a single module with no sub-modules; timer width is $clog2(TIMEOUT_CYCLES).

Verification
REQ-034 SHALL cover: key 000102..0f, text 00112233445566778899aabbccddeeff, mode 1; model returns done after 11 cycles -> one aes_ld pulse; rsp_text 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err 0, ops_cnt 1.
REQ-035 SHALL cover: model never asserts done, TIMEOUT_CYCLES 64 -> rsp_valid 64 cycles after LOAD; rsp_err 1, rsp_text 0.
REQ-036 SHALL cover: rsp_ready held 0 for 20 cycles -> rsp_valid/rsp_text stable; req_ready 0 throughout; second request accepted only after the handshake.
REQ-037 SHALL cover: done coincident with timeout expiry -> rsp_err 0, rsp_text = model output.
REQ-038 SHALL cover: rst pulsed low during WAIT, then done arrives -> no response, all outputs at reset values, ops_cnt 0.
REQ-039 SHALL cover: 65537 back-to-back operations -> ops_cnt reads 0x0001.
